llki_discrete_master: RTL

- Initiator end of the LLKI discrete key-load protocol.
- Accepts one command at a time from the host register block: load key, clear key, or query key status.
- For a load, it fetches key words from the local key memory and sends them one beat at a time to the discrete slave inside a locked core, such as the AES-192 wrapper.
- It then waits for the slave's acknowledge and reports a single status result back to the host.

---
 rtl/llki_discrete_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/llki_discrete_master.sv
// Initiator side of the LLKI discrete key-load link. It takes one host command at a time,
// streams key words from local key memory to the slave, waits for the acknowledge and reports one status.
module llki_discrete_master #(
  parameter int DATA_W      = 64,
  parameter int MAX_WORDS   = 8,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_len,
  output logic              kmem_rd,
  output logic [ADDR_W-1:0] kmem_addr,
  input  logic [DATA_W-1:0] kmem_rdata,
  output logic              llki_valid,
  input  logic              llki_ready,
  output logic [1:0]        llki_op,
  output logic [DATA_W-1:0] llki_data,
  output logic              llki_last,
  output logic              llki_abort,
  input  logic              llki_resp_valid,
  input  logic [1:0]        llki_resp_status,
  output logic              rsp_valid,
  output logic [2:0]        rsp_status,
  output logic              busy,
  output logic              key_loaded
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_ERR_OP  = 3'd1;
  localparam logic [2:0] ST_ERR_LEN = 3'd2;
  localparam logic [2:0] ST_ERR_TMO = 3'd3;
  localparam logic [2:0] ST_ERR_SLV = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [3:0]          r_len;
  logic [3:0]          r_idx;
  logic [DATA_W-1:0]   r_data;
  logic                r_cap;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [2:0]          r_status;
  logic                r_abort;
  logic                r_key_loaded;

  logic                w_accept;
  logic                w_set_status;
  logic [2:0]          w_status;
  logic                w_abort;
  logic                w_inc;
  logic                w_last;
  logic                w_tmo;
  logic                w_len_bad;
  logic [DATA_W-1:0]   w_data;

  assign w_last    = (r_op == OP_LOAD) ? (r_idx == (r_len - 4'd1)) : 1'b1;
  assign w_tmo     = (r_tcnt == TCNT_W'(TIMEOUT_CYC));
  assign w_len_bad = (cmd_len == 4'd0) || (int'(cmd_len) > MAX_WORDS);
  // Memory data arrives in the first SEND cycle; it is forwarded straight through
  // and captured so the beat stays stable however long the slave stalls.
  assign w_data    = r_cap ? kmem_rdata : r_data;

  // Valid/ready: a beat transfers on any cycle with llki_valid & llki_ready; while
  // llki_valid is high without llki_ready, op/data/last hold. Commands likewise
  // transfer on cmd_valid & cmd_ready.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_set_status = 1'b0;
    w_status     = ST_OK;
    w_abort      = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          if (cmd_op == OP_ILL) begin
            w_next       = S_DONE;
            w_set_status = 1'b1;
            w_status     = ST_ERR_OP;
          end else if (cmd_op == OP_LOAD && w_len_bad) begin
            w_next       = S_DONE;
            w_set_status = 1'b1;
            w_status     = ST_ERR_LEN;
          end else if (cmd_op == OP_LOAD) begin
            w_next = S_FETCH;
          end else begin
            w_next = S_SEND;
          end
        end
      end
      S_FETCH: w_next = S_SEND;
      S_SEND: begin
        if (llki_ready) begin
          if (w_last) begin
            w_next = S_WAIT_ACK;
          end else begin
            w_next = S_FETCH;
            w_inc  = 1'b1;
          end
        end else if (w_tmo) begin
          w_next       = S_DONE;
          w_set_status = 1'b1;
          w_status     = ST_ERR_TMO;
          w_abort      = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (llki_resp_valid) begin
          w_next       = S_DONE;
          w_set_status = 1'b1;
          w_status     = (llki_resp_status == 2'd0) ? ST_OK : ST_ERR_SLV;
        end else if (w_tmo) begin
          w_next       = S_DONE;
          w_set_status = 1'b1;
          w_status     = ST_ERR_TMO;
          w_abort      = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_len        <= 4'd0;
      r_idx        <= 4'd0;
      r_data       <= '0;
      r_cap        <= 1'b0;
      r_tcnt       <= '0;
      r_status     <= ST_OK;
      r_abort      <= 1'b0;
      r_key_loaded <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= w_abort;
      r_cap   <= (r_state == S_FETCH);
      if (w_accept) begin
        r_op   <= cmd_op;
        r_len  <= cmd_len;
        r_idx  <= 4'd0;
        r_data <= '0;
      end else if (r_cap) begin
        r_data <= kmem_rdata;
      end
      if (w_inc) begin
        r_idx <= r_idx + 4'd1;
      end
      if (r_state != w_next) begin
        r_tcnt <= '0;
      end else if (r_state == S_SEND || r_state == S_WAIT_ACK) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
      if (w_set_status) begin
        r_status <= w_status;
      end
      // A failed load leaves the slave's key state unknown, so treat it as unloaded.
      if (r_state == S_DONE) begin
        if (r_op == OP_LOAD) begin
          r_key_loaded <= (r_status == ST_OK);
        end else if (r_op == OP_CLEAR && r_status == ST_OK) begin
          r_key_loaded <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign kmem_rd    = (r_state == S_FETCH);
  assign kmem_addr  = (r_state == S_FETCH) ? ADDR_W'(r_idx) : '0;
  assign llki_valid = (r_state == S_SEND);
  assign llki_op    = (r_state == S_SEND) ? r_op : 2'b00;
  assign llki_data  = (r_state == S_SEND) ? w_data : '0;
  assign llki_last  = (r_state == S_SEND) ? w_last : 1'b0;
  assign llki_abort = r_abort;
  assign rsp_valid  = (r_state == S_DONE);
  assign rsp_status = (r_state == S_DONE) ? r_status : ST_OK;
  assign key_loaded = r_key_loaded;

endmodule
